uart_load_ctrl: RTL and testbench

Command sequencer behind the serial receiver of the SAD processor. It consumes the received byte stream (`rx_data`/`rx_ready`) and parses framed commands. Load frames are written into one of two on-chip buffers (reference block or search window), with checksum and inter-byte timeout. A start command launches the SAD core.

---
 rtl/uart_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_load_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_load_ctrl.sv
// Command sequencer behind the serial receiver of the SAD processor.
// Parses load frames (cmd, len_h, len_l, payload..., xor checksum) into the
// reference or search-window buffer, and turns a start command into a
// single-cycle launch pulse for the SAD core.
module uart_load_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              proc_busy,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              proc_start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA, CHK} state_t;

   // Last idle count that is still tolerated; a byte arriving here wins.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t            state, stateNext;
   logic [7:0]        lenHi, lenHiNext;
   logic [15:0]       remCnt, remNext;
   logic [ADDR_W-1:0] addrPtr, addrNext;
   logic [7:0]        xorAcc, xorNext;
   logic [15:0]       idleCnt, idleNext;

   logic              weNext, selNext, startNext, busyNext, doneNext, errNext;
   logic [ADDR_W-1:0] maddrNext;
   logic [7:0]        wdataNext;
   logic [1:0]        codeNext;
   logic [15:0]       lenFull;

   assign lenFull = {lenHi, rx_data};

   // Next-state and next-output decode for every received byte or timeout.
   always_comb begin
      stateNext = state;
      lenHiNext = lenHi;
      remNext   = remCnt;
      addrNext  = addrPtr;
      xorNext   = xorAcc;
      idleNext  = (rx_ready || state == IDLE) ? 16'd0 : idleCnt + 16'd1;
      weNext    = 1'b0;
      selNext   = mem_sel;
      maddrNext = mem_addr;
      wdataNext = mem_wdata;
      startNext = 1'b0;
      doneNext  = 1'b0;
      errNext   = 1'b0;
      codeNext  = err_code;

      if (rx_ready) begin
         case (state)
            IDLE: begin
               if (rx_data == 8'hA0 || rx_data == 8'hA1) begin
                  selNext   = rx_data[0];
                  codeNext  = 2'd0;
                  addrNext  = '0;
                  xorNext   = 8'd0;
                  stateNext = LEN_H;
               end else if (rx_data == 8'hB0) begin
                  if (!proc_busy) begin
                     startNext = 1'b1;
                     codeNext  = 2'd0;
                  end else begin
                     errNext  = 1'b1;
                     codeNext = 2'd3;
                  end
               end else begin
                  errNext  = 1'b1;
                  codeNext = 2'd1;
               end
            end
            LEN_H: begin
               lenHiNext = rx_data;
               stateNext = LEN_L;
            end
            LEN_L: begin
               remNext   = lenFull;
               stateNext = (lenFull == 16'd0) ? CHK : DATA;
            end
            DATA: begin
               // Write goes out at the current pointer; pointer moves on after.
               weNext    = 1'b1;
               maddrNext = addrPtr;
               wdataNext = rx_data;
               xorNext   = xorAcc ^ rx_data;
               addrNext  = addrPtr + ADDR_W'(1);
               remNext   = remCnt - 16'd1;
               if (remCnt == 16'd1) stateNext = CHK;
            end
            CHK: begin
               if (rx_data == xorAcc) begin
                  doneNext = 1'b1;
               end else begin
                  errNext  = 1'b1;
                  codeNext = 2'd2;
               end
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end else if (state != IDLE && idleCnt == TO_LAST) begin
         errNext   = 1'b1;
         codeNext  = 2'd3;
         stateNext = IDLE;
      end

      busyNext = (stateNext != IDLE);
   end

   // State, frame bookkeeping and registered outputs; reset aborts any frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lenHi      <= 8'd0;
         remCnt     <= 16'd0;
         addrPtr    <= '0;
         xorAcc     <= 8'd0;
         idleCnt    <= 16'd0;
         mem_we     <= 1'b0;
         mem_sel    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 8'd0;
         proc_start <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
      end else begin
         state      <= stateNext;
         lenHi      <= lenHiNext;
         remCnt     <= remNext;
         addrPtr    <= addrNext;
         xorAcc     <= xorNext;
         idleCnt    <= idleNext;
         mem_we     <= weNext;
         mem_sel    <= selNext;
         mem_addr   <= maddrNext;
         mem_wdata  <= wdataNext;
         proc_start <= startNext;
         busy       <= busyNext;
         done       <= doneNext;
         err        <= errNext;
         err_code   <= codeNext;
      end
   end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Self-checking bench for uart_load_ctrl, built with a 2-bit address and a
// short timeout so wrap-around and abort behaviour are reachable quickly.
module tb_uart_load_ctrl;

   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 8;
   localparam int AMOD    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              proc_busy;
   logic              mem_we;
   logic              mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              proc_start;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   int checks = 0;
   int errors = 0;
   int doneCnt = 0;
   int errCnt = 0;
   int startCnt = 0;
   logic [10:0] wrQ [$];
   logic [7:0]  pay [0:31];

   uart_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
      .proc_busy(proc_busy), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .proc_start(proc_start),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Observe writes and pulses away from the active edge.
   always @(negedge clk) begin
      if (mem_we) wrQ.push_back({mem_sel, mem_addr, mem_wdata});
      if (done) doneCnt++;
      if (err) errCnt++;
      if (proc_start) startCnt++;
   end

   // Present one byte for one cycle (called at a negedge), then idle 'gap' cycles.
   task automatic sendByte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   // Reference model: send a load frame from pay[], predict writes and outcome.
   task automatic run_frame(input logic [7:0] cmd, input logic [15:0] len,
                            input logic corrupt, input int gapMin, input int gapMax,
                            input string name);
      int wb, db, eb, n;
      logic [7:0]  x, chk;
      logic [10:0] expQ [$];
      wb = wrQ.size(); db = doneCnt; eb = errCnt;
      x = 8'd0;
      for (int i = 0; i < int'(len); i++) begin
         x ^= pay[i];
         expQ.push_back({cmd[0], ADDR_W'(i % AMOD), pay[i]});
      end
      chk = corrupt ? (x ^ 8'($urandom_range(1, 255))) : x;
      sendByte(cmd, $urandom_range(gapMin, gapMax));
      sendByte(len[15:8], $urandom_range(gapMin, gapMax));
      sendByte(len[7:0], $urandom_range(gapMin, gapMax));
      for (int i = 0; i < int'(len); i++) sendByte(pay[i], $urandom_range(gapMin, gapMax));
      sendByte(chk, 0);
      checks++;
      if (done !== !corrupt || err !== corrupt || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s end pulse: got done=%b err=%b busy=%b want done=%b err=%b busy=0",
                  name, done, err, busy, !corrupt, corrupt);
      end
      checks++;
      if (err_code !== (corrupt ? 2'd2 : 2'd0)) begin
         errors++;
         $display("FAIL %s err_code: got %0d want %0d", name, err_code, corrupt ? 2 : 0);
      end
      repeat (2) @(negedge clk);
      n = wrQ.size() - wb;
      checks++;
      if (n != expQ.size()) begin
         errors++;
         $display("FAIL %s write count: got %0d want %0d", name, n, expQ.size());
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (wrQ[wb + i] !== expQ[i]) begin
               errors++;
               $display("FAIL %s write %0d: got sel/addr/data %h want %h", name, i, wrQ[wb + i], expQ[i]);
            end
         end
      end
      checks++;
      if (doneCnt - db != int'(!corrupt) || errCnt - eb != int'(corrupt)) begin
         errors++;
         $display("FAIL %s pulse count: got done=%0d err=%0d want done=%0d err=%0d",
                  name, doneCnt - db, errCnt - eb, !corrupt, corrupt);
      end
      checks++;
      if (mem_sel !== cmd[0]) begin
         errors++;
         $display("FAIL %s mem_sel hold: got %b want %b", name, mem_sel, cmd[0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_ready = 1'b0; rx_data = 8'd0; proc_busy = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_we, mem_sel, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset mem: got we=%b sel=%b addr=%0h data=%0h want all 0", mem_we, mem_sel, mem_addr, mem_wdata);
      end
      checks++;
      if ({proc_start, busy, done, err, err_code} !== 6'd0) begin
         errors++;
         $display("FAIL reset ctrl: got start=%b busy=%b done=%b err=%b code=%0d want all 0",
                  proc_start, busy, done, err, err_code);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_ref();
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h44;
      run_frame(8'hA0, 16'd3, 1'b0, 0, 0, "load_ref");
   endtask

   task automatic test_bad_checksum();
      pay[0] = 8'h0F; pay[1] = 8'hF0;
      run_frame(8'hA1, 16'd2, 1'b1, 0, 2, "bad_chk");
   endtask

   task automatic test_zero_len_and_bad_cmd();
      int eb;
      run_frame(8'hA0, 16'd0, 1'b0, 0, 0, "zero_len");
      eb = errCnt;
      sendByte(8'h5A, 0);
      checks++;
      if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_cmd: got err=%b code=%0d busy=%b want err=1 code=1 busy=0", err, err_code, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || errCnt - eb != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_cmd single pulse: got err=%b count=%0d busy=%b want 0/1/0", err, errCnt - eb, busy);
      end
   endtask

   task automatic test_timeout();
      int wb, db;
      wb = wrQ.size(); db = doneCnt;
      sendByte(8'hA0, 0); sendByte(8'h00, 0); sendByte(8'h04, 0); sendByte(8'hAA, 0);
      repeat (7) @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout early: got err=%b busy=%b want err=0 busy=1", err, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || err_code !== 2'd3) begin
         errors++;
         $display("FAIL timeout fire: got err=%b busy=%b code=%0d want 1/0/3", err, busy, err_code);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || doneCnt != db || wrQ.size() - wb != 1 || wrQ[wb] !== {1'b0, 2'd0, 8'hAA}) begin
         errors++;
         $display("FAIL timeout after: got err=%b done=%0d writes=%0d want 0/0/1", err, doneCnt - db, wrQ.size() - wb);
      end
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      run_frame(8'hA1, 16'd4, 1'b0, 0, 3, "after_timeout");
      for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
      run_frame(8'hA0, 16'd3, 1'b0, TIMEOUT - 1, TIMEOUT - 1, "max_gap");
   endtask

   task automatic test_proc_start();
      int sb, eb;
      sb = startCnt; eb = errCnt;
      proc_busy = 1'b0;
      sendByte(8'hB0, 0);
      checks++;
      if (proc_start !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start idle: got start=%b err=%b busy=%b want 1/0/0", proc_start, err, busy);
      end
      @(negedge clk);
      checks++;
      if (proc_start !== 1'b0 || startCnt - sb != 1) begin
         errors++;
         $display("FAIL start pulse: got start=%b count=%0d want 0/1", proc_start, startCnt - sb);
      end
      proc_busy = 1'b1;
      sendByte(8'hB0, 2);
      proc_busy = 1'b0;
      checks++;
      if (startCnt - sb != 1 || errCnt - eb != 1 || err_code !== 2'd3) begin
         errors++;
         $display("FAIL start busy: got starts=%0d errs=%0d code=%0d want 1/1/3", startCnt - sb, errCnt - eb, err_code);
      end
      sendByte(8'hB0, 1);
      checks++;
      if (startCnt - sb != 2 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL start clears code: got starts=%0d code=%0d want 2/0", startCnt - sb, err_code);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) pay[i] = 8'(i + 1);
      run_frame(8'hA0, 16'd5, 1'b0, 0, 1, "wrap");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
      run_frame(8'hA1, 16'd6, 1'b0, 0, 0, "b2b_a");
      for (int i = 0; i < 7; i++) pay[i] = 8'($urandom);
      run_frame(8'hA0, 16'd7, 1'b1, 0, 0, "b2b_b");
   endtask

   task automatic test_random();
      for (int f = 0; f < 25; f++) begin
         int len;
         len = $urandom_range(0, 12);
         for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
         run_frame($urandom_range(0, 1) ? 8'hA1 : 8'hA0, 16'(len),
                   ($urandom_range(0, 3) == 0), 0, TIMEOUT - 1, "random");
      end
   endtask

   task automatic test_rst_mid();
      int db, eb;
      sendByte(8'hA1, 0); sendByte(8'h00, 0); sendByte(8'h05, 0);
      sendByte(8'h01, 0); sendByte(8'h02, 0);
      db = doneCnt; eb = errCnt;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mem_we, mem_sel, mem_addr, mem_wdata, busy, err_code} !== '0) begin
         errors++;
         $display("FAIL rst_mid outputs: got we=%b sel=%b addr=%0h data=%0h busy=%b code=%0d want all 0",
                  mem_we, mem_sel, mem_addr, mem_wdata, busy, err_code);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (TIMEOUT + 4) @(negedge clk);
      checks++;
      if (doneCnt != db || errCnt != eb || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid pulses: got done=%0d err=%0d busy=%b want 0/0/0", doneCnt - db, errCnt - eb, busy);
      end
      for (int i = 0; i < 2; i++) pay[i] = 8'($urandom);
      run_frame(8'hA0, 16'd2, 1'b0, 0, 2, "after_rst");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_ref();
      test_bad_checksum();
      test_zero_len_and_bad_cmd();
      test_timeout();
      test_proc_start();
      test_wrap();
      test_back_to_back();
      test_random();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
